// File: rtl/uart_demod_rx_if.sv
// Serial pin and reassembled-word outputs of the demod UART receiver.
// Signals: uart_rxd (serial in, idle high), demod_out/demod_valid (word + strobe),
//          frame_err/sync_err (error strobes), busy (bit receiver active).
interface uart_demod_rx_if;
    logic        uart_rxd;
    logic [11:0] demod_out;
    logic        demod_valid;
    logic        frame_err;
    logic        sync_err;
    logic        busy;

    // master: the receiver itself; slave: whoever drives the pin and consumes words
    modport master (
        input  uart_rxd,
        output demod_out, demod_valid, frame_err, sync_err, busy
    );
    modport slave (
        output uart_rxd,
        input  demod_out, demod_valid, frame_err, sync_err, busy
    );
endinterface

// File: rtl/uart_demod_rx.sv
// Purpose: 8N1 UART receiver that pairs bytes {0000,d[11:8]} then d[7:0] into 12-bit demod words.
// Latency: demod_valid one cycle after the bottom byte's stop sample (~9.5 bit periods + 2-3 clk).
// Backpressure: none; words and error strobes are single-cycle pulses that must be taken when seen.
// Ports: clk, reset (async active-high), rx (uart_demod_rx_if.master: uart_rxd in; demod_out,
//        demod_valid, frame_err, sync_err, busy out).
module uart_demod_rx #(
    parameter int CLK_HZ       = 100000000,
    parameter int BIT_RATE     = 115200,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic            clk,
    input  logic            reset,
    uart_demod_rx_if.master rx
);
    localparam int CLKS_PER_BIT = CLK_HZ / BIT_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int TIMEOUT_CYC  = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int CW           = $clog2(CLKS_PER_BIT + 1);
    localparam int TW           = $clog2(TIMEOUT_CYC + 1);

    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    // ------------------------------------------------------------------
    // Input synchroniser; rxs_d is kept for falling-edge detection.
    // Preset to 1 so a reset does not look like a start edge.
    // ------------------------------------------------------------------
    logic rx_meta, rxs, rxs_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx.uart_rxd;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    // ------------------------------------------------------------------
    // Bit receiver
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_state_t;

    bit_state_t    bit_state, bit_next;
    logic [CW-1:0] clk_cnt, clk_cnt_next;
    logic [2:0]    bit_idx, bit_idx_next;
    logic [7:0]    shreg, shreg_next;
    logic          byte_ok;   // stop bit sampled high this cycle; shreg holds the byte
    logic          stop_bad;  // stop bit sampled low this cycle

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_state <= IDLE;
            clk_cnt   <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
        end else begin
            bit_state <= bit_next;
            clk_cnt   <= clk_cnt_next;
            bit_idx   <= bit_idx_next;
            shreg     <= shreg_next;
        end
    end

    always_comb begin
        bit_next     = bit_state;
        clk_cnt_next = clk_cnt + 1'b1;
        bit_idx_next = bit_idx;
        shreg_next   = shreg;
        byte_ok      = 1'b0;
        stop_bad     = 1'b0;
        case (bit_state)
            IDLE: begin
                clk_cnt_next = '0;
                if (rxs_d && !rxs) begin
                    bit_next     = START;
                    bit_idx_next = '0;
                end
            end
            START: begin
                // Mid-start-bit check: a line that is high again was only a glitch.
                if (clk_cnt == HALF_LAST) begin
                    clk_cnt_next = '0;
                    bit_next     = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    shreg_next   = {rxs, shreg[7:1]};
                    bit_idx_next = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) begin
                        bit_next = STOP;
                    end
                end
            end
            STOP: begin
                // Back to IDLE at mid-stop so a start edge in the second half is caught.
                if (clk_cnt == BIT_LAST) begin
                    clk_cnt_next = '0;
                    bit_next     = IDLE;
                    if (rxs) begin
                        byte_ok = 1'b1;
                    end else begin
                        stop_bad = 1'b1;
                    end
                end
            end
            default: begin
                bit_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Word assembler
    // ------------------------------------------------------------------
    typedef enum logic {WAIT_HI, WAIT_LO} asm_state_t;

    asm_state_t    asm_state, asm_next;
    logic [3:0]    hi_nib, hi_nib_next;
    logic [TW-1:0] tmo_cnt, tmo_cnt_next;
    logic [11:0]   demod_q, demod_next;
    logic          valid_q, valid_next;
    logic          ferr_q;
    logic          serr_q, serr_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_state <= WAIT_HI;
            hi_nib    <= '0;
            tmo_cnt   <= '0;
            demod_q   <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            serr_q    <= 1'b0;
        end else begin
            asm_state <= asm_next;
            hi_nib    <= hi_nib_next;
            tmo_cnt   <= tmo_cnt_next;
            demod_q   <= demod_next;
            valid_q   <= valid_next;
            ferr_q    <= stop_bad;
            serr_q    <= serr_next;
        end
    end

    always_comb begin
        asm_next     = asm_state;
        hi_nib_next  = hi_nib;
        tmo_cnt_next = tmo_cnt;
        demod_next   = demod_q;
        valid_next   = 1'b0;
        serr_next    = 1'b0;
        case (asm_state)
            WAIT_HI: begin
                if (byte_ok) begin
                    if (shreg[7:4] == 4'h0) begin
                        hi_nib_next  = shreg[3:0];
                        tmo_cnt_next = '0;
                        asm_next     = WAIT_LO;
                    end else begin
                        serr_next = 1'b1;
                    end
                end
            end
            WAIT_LO: begin
                tmo_cnt_next = tmo_cnt + 1'b1;
                // Priority: accepted byte beats a coincident timeout; a framing
                // error drops the pair without also flagging sync_err.
                if (byte_ok) begin
                    demod_next = {hi_nib, shreg};
                    valid_next = 1'b1;
                    asm_next   = WAIT_HI;
                end else if (stop_bad) begin
                    asm_next = WAIT_HI;
                end else if (tmo_cnt == TMO_LAST) begin
                    serr_next = 1'b1;
                    asm_next  = WAIT_HI;
                end
            end
            default: begin
                asm_next = WAIT_HI;
            end
        endcase
    end

    assign rx.demod_out   = demod_q;
    assign rx.demod_valid = valid_q;
    assign rx.frame_err   = ferr_q;
    assign rx.sync_err    = serr_q;
    assign rx.busy        = (bit_state != IDLE);

endmodule

// File: doc/uart_demod_rx.md
Name: uart_demod_rx

Overview:
- UART receiver plus word reassembler: the receive end of the demod-data UART link.
- Deserialises 8N1 bytes from an asynchronous serial pin and pairs them into 12-bit demod words.
- The top byte carries {4'b0000, demod[11:8]} and is sent first; the bottom byte carries demod[7:0].
- Used on the capture/bench side, or in loopback against the demod transmit path.

Parameters:
- CLK_HZ, 100000000, system clock frequency in Hz.
- BIT_RATE, 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BIT_RATE (integer divide, 868 at defaults).
- TIMEOUT_BITS, 20, maximum gap in bit periods between top and bottom byte before the pairing is abandoned.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- uart_rxd  input  1  serial input, idle high, asynchronous to clk.
- demod_out  output  12  last reassembled demod word.
- demod_valid  output  1  one-cycle pulse; demod_out is new.
- frame_err  output  1  one-cycle pulse; stop bit sampled low.
- sync_err  output  1  one-cycle pulse; pairing violation (bad top byte or timeout).
- busy  output  1  high while the bit receiver is not in IDLE.

Behaviour:
- Reset values: demod_out=0, demod_valid=0, frame_err=0, sync_err=0, busy=0. Bit FSM in IDLE, assembler in WAIT_HI, synchroniser flops preset to 1.
- A reset asserted mid-frame or mid-pair aborts it immediately. No output pulse results, and the partial byte and any held top byte are discarded.
- uart_rxd passes through a 2-flop synchroniser (rxs). All decisions use rxs.
- Bit FSM states: IDLE, START, DATA, STOP.
  - IDLE: a falling edge on rxs (previous 1, current 0) -> START, bit counter cleared.
  - START: count CLKS_PER_BIT/2 cycles, then sample rxs. If 0 -> DATA (start confirmed). If 1 -> IDLE (glitch, no error).
  - DATA: every CLKS_PER_BIT cycles sample rxs into the shift register, LSB first. After the 8th sample -> STOP.
  - STOP: after CLKS_PER_BIT cycles sample rxs. If 1, the byte is accepted. If 0, frame_err pulses and the byte is dropped. Either way -> IDLE in the same edge, so a start edge in the second half of the stop bit is detected.
- busy = (state != IDLE).
- Assembler states: WAIT_HI, WAIT_LO.
  - WAIT_HI, byte accepted with byte[7:4]==0: store byte[3:0], clear the timeout counter, -> WAIT_LO.
  - WAIT_HI, byte accepted with byte[7:4]!=0: sync_err pulses, byte discarded, stay in WAIT_HI.
  - WAIT_LO, byte accepted: demod_out <= {stored nibble, byte}, demod_valid pulses, -> WAIT_HI.
  - WAIT_LO timeout: the counter increments every cycle. Reaching TIMEOUT_BITS*CLKS_PER_BIT with no accepted byte -> sync_err pulses, -> WAIT_HI.
  - frame_err while in WAIT_LO also drops the held nibble and returns to WAIT_HI. Only frame_err pulses in that case (no sync_err).
- Timing: demod_valid rises in the cycle after the clock edge that samples the bottom byte's stop bit as 1. This is 9.5 bit periods + 2-3 cycles after the bottom byte's start edge at uart_rxd. demod_out holds its value until the next valid word.
- All three pulses are exactly one clk cycle wide. frame_err and demod_valid cannot coincide.
- If a timeout and a byte acceptance occur on the same edge, the byte wins and no sync_err is raised.
- Width: the timeout counter must hold TIMEOUT_BITS*CLKS_PER_BIT (15 bits at defaults).

Test Plan:
- Send 0x0A then 0xBC back-to-back at 115200 -> exactly one demod_valid pulse with demod_out=0xABC; no frame_err or sync_err.
- Send the pairs (0x0F,0xFF) then (0x00,0x00) -> demod_out=0xFFF, then 0x000; two demod_valid pulses.
- Send 0x5A as the first byte -> one sync_err pulse; then 0x01,0x23 -> demod_out=0x123.
- Send 0x03, idle 25 bit periods, then 0x04,0x56 -> sync_err at 20 bit periods after the 0x03 stop sample; then demod_out=0x456, and 0x03 never appears.
- Send 0x07 then a frame with the stop bit forced 0; also drive a 0.3-bit low glitch on an idle line -> frame_err pulse and assembler back in WAIT_HI; the glitch causes no pulses and busy returns to 0.
- Assert reset mid-way through the bottom byte, release it, then send 0x0C,0xDE -> no output from the aborted pair; demod_out=0xCDE.
